// File: rtl/rv_ex_pkg.sv
// Shared opcode constants and MD state type for the execute stage.
package rv_ex_pkg;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [2:0] BrEq  = 3'b000;
    localparam logic [2:0] BrNe  = 3'b001;
    localparam logic [2:0] BrLt  = 3'b100;
    localparam logic [2:0] BrGe  = 3'b101;
    localparam logic [2:0] BrLtu = 3'b110;
    localparam logic [2:0] BrGeu = 3'b111;

    localparam logic [2:0] MdMul    = 3'b000;
    localparam logic [2:0] MdMulh   = 3'b001;
    localparam logic [2:0] MdMulhsu = 3'b010;
    localparam logic [2:0] MdMulhu  = 3'b011;
    localparam logic [2:0] MdDiv    = 3'b100;
    localparam logic [2:0] MdDivu   = 3'b101;
    localparam logic [2:0] MdRem    = 3'b110;
    localparam logic [2:0] MdRemu   = 3'b111;

    typedef enum logic [1:0] {
        MdIdle,
        MdBusy,
        MdDone
    } mdState_e;

endpackage

// File: rtl/execute_stage_md_if.sv
// Execute-stage bus: decoded operands/controls in, EX/MEM register and redirect out.
interface execute_stage_md_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] RD1_E, RD2_E, PCE, PCPlus4E, Imm_Ext_E;
    logic [XLEN-1:0] ResultW, ALUResultM_E;
    logic            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE, BranchCondE;
    logic            MDValidE;
    logic [2:0]      MDOpE;
    logic [4:0]      RD_E;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            FlushE;

    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]      RD_M;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE;
    logic            MDBusyE;

    modport master (
        output RD1_E, RD2_E, PCE, PCPlus4E, Imm_Ext_E, ResultW, ALUResultM_E,
        output RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE,
        output ALUControlE, BranchCondE, MDValidE, MDOpE, RD_E,
        output ForwardAE, ForwardBE, FlushE,
        input  ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
        input  ResultSrcM, PCTargetE, PCSrcE, MDBusyE
    );

    modport slave (
        input  RD1_E, RD2_E, PCE, PCPlus4E, Imm_Ext_E, ResultW, ALUResultM_E,
        input  RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE,
        input  ALUControlE, BranchCondE, MDValidE, MDOpE, RD_E,
        input  ForwardAE, ForwardBE, FlushE,
        output ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
        output ResultSrcM, PCTargetE, PCSrcE, MDBusyE
    );

endinterface

// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply/divide: one bit per cycle on operand magnitudes,
// sign fix-up applied combinationally to the result while in MdDone.
module md_iter_unit
    import rv_ex_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);

    mdState_e        stateQ;
    logic [CntW-1:0] cntQ;
    logic [2:0]      opQ;
    logic            negQ, divZeroQ;
    logic [XLEN-1:0] bQ, hiQ, loQ;

    logic            isDiv, signA, signB, negA, negB;
    logic [XLEN-1:0] magA, magB, hiD, loD, quo, rem;
    logic [XLEN:0]   mulSum, remShift;
    logic [XLEN+1:0] trial;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        isDiv = op[2];
        signA = isDiv ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        signB = isDiv ? ~op[0] : (op[1:0] == 2'b01);
        negA  = signA & opA[XLEN-1];
        negB  = signB & opB[XLEN-1];
        magA  = negA ? -opA : opA;
        magB  = negB ? -opB : opB;
    end

    // hi:lo is the product (shift right) or remainder:quotient (shift left).
    always_comb begin
        mulSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, bQ} : '0);
        remShift = {hiQ, loQ[XLEN-1]};
        trial    = {1'b0, remShift} - {2'b00, bQ};
        if (opQ[2]) begin
            hiD = trial[XLEN+1] ? remShift[XLEN-1:0] : trial[XLEN-1:0];
            loD = {loQ[XLEN-2:0], ~trial[XLEN+1]};
        end else begin
            hiD = mulSum[XLEN:1];
            loD = {mulSum[0], loQ[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= MdIdle;
            cntQ     <= '0;
            opQ      <= '0;
            negQ     <= 1'b0;
            divZeroQ <= 1'b0;
            bQ       <= '0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            case (stateQ)
                MdIdle: begin
                    if (valid && !flush) begin
                        stateQ   <= MdBusy;
                        cntQ     <= '0;
                        opQ      <= op;
                        // Remainder takes the dividend's sign; everything else the xor.
                        negQ     <= (isDiv && op[1]) ? negA : (negA ^ negB);
                        divZeroQ <= isDiv && (opB == '0);
                        bQ       <= magB;
                        hiQ      <= '0;
                        loQ      <= magA;
                    end
                end
                MdBusy: begin
                    if (flush) begin
                        stateQ <= MdIdle;
                    end else begin
                        hiQ  <= hiD;
                        loQ  <= loD;
                        cntQ <= cntQ + 1'b1;
                        if (cntQ == CntW'(XLEN - 1)) stateQ <= MdDone;
                    end
                end
                default: stateQ <= MdIdle;
            endcase
        end
    end

    assign busy = (stateQ == MdBusy) || (stateQ == MdIdle && valid);
    assign done = (stateQ == MdDone);

    always_comb begin
        prod = {hiQ, loQ};
        if (negQ) prod = -prod;
        quo = negQ ? -loQ : loQ;
        rem = negQ ? -hiQ : hiQ;
        case (opQ)
            MdMul:                     result = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: result = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             result = divZeroQ ? '1 : quo;
            default:                   result = rem;
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: forwarding, ALU, branch resolution, MD unit hookup and EX/MEM register.
module execute_stage_md
    import rv_ex_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          MD_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    execute_stage_md_if.slave ex
);

    logic [XLEN-1:0] srcA, srcBFwd, srcB, aluResult, mdResult;
    logic            eq, ltS, ltU, condMet;
    logic            mdValid, mdBusy, mdDone;

    logic [XLEN-1:0] aluResultQ, writeDataQ, pcPlus4Q;
    logic [4:0]      rdQ;
    logic            regWriteQ, memWriteQ;
    logic [1:0]      resultSrcQ;

    always_comb begin
        case (ex.ForwardAE)
            2'b01:   srcA = ex.ResultW;
            2'b10:   srcA = ex.ALUResultM_E;
            default: srcA = ex.RD1_E;
        endcase
        case (ex.ForwardBE)
            2'b01:   srcBFwd = ex.ResultW;
            2'b10:   srcBFwd = ex.ALUResultM_E;
            default: srcBFwd = ex.RD2_E;
        endcase
        srcB = ex.ALUSrcE ? ex.Imm_Ext_E : srcBFwd;
    end

    always_comb begin
        case (ex.ALUControlE)
            AluAdd:  aluResult = srcA + srcB;
            AluSub:  aluResult = srcA - srcB;
            AluAnd:  aluResult = srcA & srcB;
            AluOr:   aluResult = srcA | srcB;
            AluSlt:  aluResult = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            default: aluResult = '0;
        endcase
    end

    // Branches compare register operands, never the immediate.
    always_comb begin
        eq  = (srcA == srcBFwd);
        ltS = $signed(srcA) < $signed(srcBFwd);
        ltU = srcA < srcBFwd;
        case (ex.BranchCondE)
            BrEq:    condMet = eq;
            BrNe:    condMet = ~eq;
            BrLt:    condMet = ltS;
            BrGe:    condMet = ~ltS;
            BrLtu:   condMet = ltU;
            BrGeu:   condMet = ~ltU;
            default: condMet = 1'b0;
        endcase
    end

    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
    assign ex.PCSrcE    = ~ex.FlushE & ((ex.BranchE & condMet) | ex.JumpE);
    assign mdValid      = MD_EN & ex.MDValidE;
    assign ex.MDBusyE   = mdBusy;

    md_iter_unit #(
        .XLEN(XLEN)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .valid (mdValid),
        .flush (ex.FlushE),
        .op    (ex.MDOpE),
        .opA   (srcA),
        .opB   (srcBFwd),
        .busy  (mdBusy),
        .done  (mdDone),
        .result(mdResult)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluResultQ <= '0;
            writeDataQ <= '0;
            pcPlus4Q   <= '0;
            rdQ        <= '0;
            regWriteQ  <= 1'b0;
            memWriteQ  <= 1'b0;
            resultSrcQ <= '0;
        end else if (mdBusy || ex.FlushE) begin
            aluResultQ <= '0;
            writeDataQ <= '0;
            pcPlus4Q   <= '0;
            rdQ        <= '0;
            regWriteQ  <= 1'b0;
            memWriteQ  <= 1'b0;
            resultSrcQ <= '0;
        end else begin
            aluResultQ <= mdDone ? mdResult : aluResult;
            writeDataQ <= srcBFwd;
            pcPlus4Q   <= ex.PCPlus4E;
            rdQ        <= ex.RD_E;
            regWriteQ  <= ex.RegWriteE;
            memWriteQ  <= ex.MemWriteE;
            resultSrcQ <= ex.ResultSrcE;
        end
    end

    assign ex.ALUResultM = aluResultQ;
    assign ex.WriteDataM = writeDataQ;
    assign ex.PCPlus4M   = pcPlus4Q;
    assign ex.RD_M       = rdQ;
    assign ex.RegWriteM  = regWriteQ;
    assign ex.MemWriteM  = memWriteQ;
    assign ex.ResultSrcM = resultSrcQ;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md; a second MD_EN=0 instance mirrors the same inputs.
module tb_execute_stage_md;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] res;
    int          busyCycles;
    logic        regW;
    logic        sawRegW;

    execute_stage_md_if #(.XLEN(32)) bus ();
    execute_stage_md_if #(.XLEN(32)) bus0 ();

    execute_stage_md #(.XLEN(32), .MD_EN(1'b1)) dut (.clk(clk), .rst(rst), .ex(bus));
    execute_stage_md #(.XLEN(32), .MD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .ex(bus0));

    assign bus0.RD1_E        = bus.RD1_E;
    assign bus0.RD2_E        = bus.RD2_E;
    assign bus0.PCE          = bus.PCE;
    assign bus0.PCPlus4E     = bus.PCPlus4E;
    assign bus0.Imm_Ext_E    = bus.Imm_Ext_E;
    assign bus0.ResultW      = bus.ResultW;
    assign bus0.ALUResultM_E = bus.ALUResultM_E;
    assign bus0.RegWriteE    = bus.RegWriteE;
    assign bus0.MemWriteE    = bus.MemWriteE;
    assign bus0.ALUSrcE      = bus.ALUSrcE;
    assign bus0.BranchE      = bus.BranchE;
    assign bus0.JumpE        = bus.JumpE;
    assign bus0.ResultSrcE   = bus.ResultSrcE;
    assign bus0.ALUControlE  = bus.ALUControlE;
    assign bus0.BranchCondE  = bus.BranchCondE;
    assign bus0.MDValidE     = bus.MDValidE;
    assign bus0.MDOpE        = bus.MDOpE;
    assign bus0.RD_E         = bus.RD_E;
    assign bus0.ForwardAE    = bus.ForwardAE;
    assign bus0.ForwardBE    = bus.ForwardBE;
    assign bus0.FlushE       = bus.FlushE;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus.RD1_E = '0; bus.RD2_E = '0; bus.PCE = '0; bus.PCPlus4E = '0;
        bus.Imm_Ext_E = '0; bus.ResultW = '0; bus.ALUResultM_E = '0;
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.ALUSrcE = 0; bus.BranchE = 0;
        bus.JumpE = 0; bus.ResultSrcE = '0; bus.ALUControlE = '0; bus.BranchCondE = '0;
        bus.MDValidE = 0; bus.MDOpE = '0; bus.RD_E = '0; bus.ForwardAE = '0;
        bus.ForwardBE = '0; bus.FlushE = 0;
    endtask

    // Issue an MD op, count MDBusyE-high cycles, then capture the EX/MEM result.
    task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int cyc, output logic rw);
        clearIn();
        bus.RD1_E = a; bus.RD2_E = b; bus.MDOpE = op; bus.MDValidE = 1;
        bus.RegWriteE = 1; bus.RD_E = 5'd9;
        cyc = 0;
        #1;
        while (bus.MDBusyE === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        tick();
        r  = bus.ALUResultM;
        rw = bus.RegWriteM;
        bus.MDValidE = 0;
        bus.RegWriteE = 0;
    endtask

    initial begin
        clearIn();
        rst = 0;
        tick();
        check("rst_alu", bus.ALUResultM, 32'h0);
        check("rst_regw", {31'b0, bus.RegWriteM}, 32'h0);
        check("rst_busy", {31'b0, bus.MDBusyE}, 32'h0);
        check("rst_pcsrc", {31'b0, bus.PCSrcE}, 32'h0);
        rst = 1;

        // Forward from MEM stage into A
        bus.ForwardAE = 2'b10; bus.ALUResultM_E = 32'd5; bus.RD1_E = 32'd100;
        bus.RD2_E = 32'd3; bus.ALUControlE = 3'b000; bus.RegWriteE = 1; bus.MemWriteE = 1;
        bus.RD_E = 5'd7; bus.PCPlus4E = 32'h104; bus.ResultSrcE = 2'b01;
        tick();
        check("fwdm_add", bus.ALUResultM, 32'd8);
        check("fwdm_wdata", bus.WriteDataM, 32'd3);
        check("fwdm_rd", {27'b0, bus.RD_M}, 32'd7);
        check("fwdm_pc4", bus.PCPlus4M, 32'h104);
        check("fwdm_ctl", {28'b0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM}, 32'hD);

        // SUB with immediate, A from ResultW
        bus.ForwardAE = 2'b01; bus.ResultW = 32'd10; bus.ALUSrcE = 1; bus.Imm_Ext_E = 32'd15;
        bus.ALUControlE = 3'b001; bus.MemWriteE = 0; bus.PCE = 32'h100;
        #1;
        check("pctarget", bus.PCTargetE, 32'h10F);
        tick();
        check("sub_imm", bus.ALUResultM, 32'hFFFF_FFFB);
        check("sub_wdata", bus.WriteDataM, 32'd3);

        // SLT, select 11 acts as register operand
        bus.ForwardAE = 2'b11; bus.RD1_E = 32'hFFFF_FFFF; bus.ALUSrcE = 0;
        bus.ForwardBE = 2'b01; bus.ResultW = 32'd1; bus.ALUControlE = 3'b101;
        tick();
        check("slt", bus.ALUResultM, 32'd1);
        check("slt_wdata", bus.WriteDataM, 32'd1);

        bus.ForwardAE = 2'b00; bus.RD1_E = 32'h0000_FF00;
        bus.ForwardBE = 2'b10; bus.ALUResultM_E = 32'h0000_0F0F; bus.ALUControlE = 3'b010;
        tick();
        check("and", bus.ALUResultM, 32'h0000_0F00);
        bus.ALUControlE = 3'b011;
        tick();
        check("or", bus.ALUResultM, 32'h0000_FF0F);
        bus.ALUControlE = 3'b111;
        tick();
        check("alu_undef", bus.ALUResultM, 32'h0);

        bus.PCE = 32'hFFFF_FFF0; bus.Imm_Ext_E = 32'h20;
        #1;
        check("pctarget_wrap", bus.PCTargetE, 32'h10);

        // Branch conditions, combinational
        clearIn();
        bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1; bus.BranchE = 1; bus.BranchCondE = 3'b100;
        #1; check("br_lt", {31'b0, bus.PCSrcE}, 32'd1);
        bus.BranchCondE = 3'b110;
        #1; check("br_ltu", {31'b0, bus.PCSrcE}, 32'd0);
        bus.BranchCondE = 3'b101;
        #1; check("br_ge", {31'b0, bus.PCSrcE}, 32'd0);
        bus.BranchCondE = 3'b111;
        #1; check("br_geu", {31'b0, bus.PCSrcE}, 32'd1);
        bus.RD1_E = 32'd5; bus.RD2_E = 32'd5; bus.BranchCondE = 3'b010;
        #1; check("br_010", {31'b0, bus.PCSrcE}, 32'd0);
        bus.BranchCondE = 3'b000;
        #1; check("br_eq", {31'b0, bus.PCSrcE}, 32'd1);
        bus.BranchCondE = 3'b001;
        #1; check("br_ne", {31'b0, bus.PCSrcE}, 32'd0);
        bus.BranchE = 0; bus.JumpE = 1;
        #1; check("jump", {31'b0, bus.PCSrcE}, 32'd1);
        bus.FlushE = 1; bus.RegWriteE = 1; bus.RD_E = 5'd3;
        #1; check("flush_pcsrc", {31'b0, bus.PCSrcE}, 32'd0);
        tick();
        check("flush_bubble", {31'b0, bus.RegWriteM}, 32'd0);
        check("flush_alu", bus.ALUResultM, 32'd0);

        // Multiply / divide
        runMd(3'b000, 32'd7, 32'hFFFF_FFFD, res, busyCycles, regW);
        check("mul_busy", busyCycles, 32'd33);
        check("mul_res", res, 32'hFFFF_FFEB);
        check("mul_regw", {31'b0, regW}, 32'd1);
        runMd(3'b001, 32'd7, 32'hFFFF_FFFD, res, busyCycles, regW);
        check("mulh", res, 32'hFFFF_FFFF);
        runMd(3'b010, 32'hFFFF_FFFF, 32'd2, res, busyCycles, regW);
        check("mulhsu", res, 32'hFFFF_FFFF);
        runMd(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, busyCycles, regW);
        check("mulhu", res, 32'hFFFF_FFFE);
        runMd(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, res, busyCycles, regW);
        check("div_ovf", res, 32'h8000_0000);
        runMd(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, busyCycles, regW);
        check("rem_ovf", res, 32'h0);
        runMd(3'b111, 32'd9, 32'd0, res, busyCycles, regW);
        check("remu_div0", res, 32'd9);
        runMd(3'b101, 32'd9, 32'd0, res, busyCycles, regW);
        check("divu_div0", res, 32'hFFFF_FFFF);
        runMd(3'b100, 32'hFFFF_FFF9, 32'd0, res, busyCycles, regW);
        check("div_div0", res, 32'hFFFF_FFFF);
        runMd(3'b100, 32'hFFFF_FFF9, 32'd2, res, busyCycles, regW);
        check("div_neg", res, 32'hFFFF_FFFD);
        runMd(3'b110, 32'hFFFF_FFF9, 32'd2, res, busyCycles, regW);
        check("rem_neg", res, 32'hFFFF_FFFF);

        // Flush during BUSY cycle 10
        clearIn();
        bus.RD1_E = 32'd11; bus.RD2_E = 32'd13; bus.MDValidE = 1; bus.RegWriteE = 1;
        sawRegW = 0;
        repeat (10) begin
            tick();
            if (bus.RegWriteM) sawRegW = 1;
        end
        check("busy_before_flush", {31'b0, bus.MDBusyE}, 32'd1);
        bus.FlushE = 1;
        tick();
        bus.FlushE = 0; bus.MDValidE = 0; bus.RegWriteE = 0;
        #1;
        check("flush_idle", {31'b0, bus.MDBusyE}, 32'd0);
        repeat (40) begin
            tick();
            if (bus.RegWriteM || bus.MDBusyE) sawRegW = 1;
        end
        check("flush_no_write", {31'b0, sawRegW}, 32'd0);

        // Asynchronous reset between edges
        clearIn();
        bus.RD1_E = 32'd2; bus.RD2_E = 32'd3; bus.RegWriteE = 1;
        tick();
        check("pre_rst_alu", bus.ALUResultM, 32'd5);
        #2 rst = 0;
        #1;
        check("async_rst_alu", bus.ALUResultM, 32'd0);
        check("async_rst_regw", {31'b0, bus.RegWriteM}, 32'd0);
        @(negedge clk);
        rst = 1;

        // Divide interrupted by reset; MD_EN=0 twin completes it as an ADD
        clearIn();
        bus.RD1_E = 32'd100; bus.RD2_E = 32'd7; bus.MDOpE = 3'b100; bus.MDValidE = 1;
        bus.RegWriteE = 1; bus.RD_E = 5'd4;
        tick();
        check("noMd_alu", bus0.ALUResultM, 32'd107);
        check("noMd_regw", {31'b0, bus0.RegWriteM}, 32'd1);
        check("noMd_busy", {31'b0, bus0.MDBusyE}, 32'd0);
        check("div_bubble", {31'b0, bus.RegWriteM}, 32'd0);
        repeat (4) tick();
        #2 rst = 0; bus.MDValidE = 0;
        #1;
        check("middiv_rst_busy", {31'b0, bus.MDBusyE}, 32'd0);
        check("middiv_rst_alu", bus.ALUResultM, 32'd0);
        @(negedge clk);
        rst = 1;
        runMd(3'b000, 32'd6, 32'd7, res, busyCycles, regW);
        check("post_rst_busy", busyCycles, 32'd33);
        check("post_rst_mul", res, 32'd42);
        check("post_rst_regw", {31'b0, regW}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
